// File: rtl/planificador_serial.sv
// Round-robin scheduler: shares one serializer among NUM_CH show-ahead lane FIFOs, bursts of up to MAX_BURST words.
// Latency: pop is combinational; the popped word appears on data_out/valid_out one clk_4f cycle later.
// Backpressure: none from the serializer; idle cycles drive valid_out low (serializer sends COM), every burst ends in a gap.
module planificador_serial #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int INIT_COMS = 4,
  parameter int MAX_BURST = 4,
  localparam int CW = $clog2(NUM_CH),
  localparam int BW = $clog2(MAX_BURST + 1),
  localparam int IW = $clog2(INIT_COMS + 1)
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*WIDTH-1:0]   req_data,
  output logic [NUM_CH-1:0]         pop,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [CW-1:0]             ch_out,
  output logic                      busy
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_COMS - 1);

  logic [1:0]       r_state;
  logic [IW-1:0]    r_init_cnt;
  logic [BW-1:0]    r_burst_cnt;
  logic [CW-1:0]    r_last_ch;
  logic [CW-1:0]    r_cur_ch;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CW-1:0]    r_ch;
  logic             r_busy;

  logic [WIDTH-1:0] w_lane [NUM_CH];
  logic [CW-1:0]    w_cand;
  logic [CW-1:0]    w_win;
  logic             w_found;
  logic             w_burst_more;
  logic             w_grant;
  logic [CW-1:0]    w_sel;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign w_lane[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: first requesting lane after the last served one, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = CW'((int'(r_last_ch) + k) % NUM_CH);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // A burst continues only while its lane still has data and the burst budget is not spent.
  assign w_burst_more = req_valid[r_cur_ch] && (r_burst_cnt < BURST_MAX);
  // Gating with reset drops pop the instant reset asserts, even mid-burst.
  assign w_grant = reset && (((r_state == S_IDLE) && enable && w_found) ||
                             ((r_state == S_BURST) && w_burst_more));
  assign w_sel   = (r_state == S_BURST) ? r_cur_ch : w_win;
  assign pop     = w_grant ? (NUM_CH'(1) << w_sel) : '0;

  // Scheduler state machine and registered serializer-side outputs.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_burst_cnt <= '0;
      r_last_ch   <= CW'(NUM_CH - 1);
      r_cur_ch    <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ch        <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_valid    <= 1'b0;
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == INIT_LAST) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_grant) begin
            r_data      <= w_lane[w_sel];
            r_valid     <= 1'b1;
            r_ch        <= w_sel;
            r_cur_ch    <= w_sel;
            r_burst_cnt <= BW'(1);
            if (MAX_BURST == 1) begin
              r_last_ch <= w_sel;
            end else begin
              r_state <= S_BURST;
              r_busy  <= 1'b1;
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_BURST: begin
          if (w_grant) begin
            r_data      <= w_lane[w_sel];
            r_valid     <= 1'b1;
            r_ch        <= r_cur_ch;
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end else begin
            // One idle cycle separates bursts so the serializer inserts a COM.
            r_valid   <= 1'b0;
            r_last_ch <= r_cur_ch;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign ch_out    = r_ch;
  assign busy      = r_busy;

endmodule
